// File: rtl/fft_pkg.sv
// Shared constants, types and saturation helper for the 4-point FFT datapath.
package fft_pkg;

    localparam int FFT4_N      = 4;
    localparam int SCALE_SAT   = 0;
    localparam int SCALE_SHIFT = 1;
    localparam int CPLX_W      = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic logic signed [63:0] sat(
        input logic signed [63:0] x,
        input int                 ow
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// Complex radix-2 butterfly: sum and difference, optional floor divide by 2.
module fft_bfly2 #(
    parameter int IW    = 16,
    parameter int SHIFT = 0,
    localparam int OW   = IW + 1 - SHIFT
) (
    input  logic signed [IW-1:0] i_a_re,
    input  logic signed [IW-1:0] i_a_im,
    input  logic signed [IW-1:0] i_b_re,
    input  logic signed [IW-1:0] i_b_im,
    output logic signed [OW-1:0] o_s_re,
    output logic signed [OW-1:0] o_s_im,
    output logic signed [OW-1:0] o_d_re,
    output logic signed [OW-1:0] o_d_im
);

    logic signed [IW:0] w_s_re;
    logic signed [IW:0] w_s_im;
    logic signed [IW:0] w_d_re;
    logic signed [IW:0] w_d_im;

    assign w_s_re = (IW+1)'(i_a_re) + (IW+1)'(i_b_re);
    assign w_s_im = (IW+1)'(i_a_im) + (IW+1)'(i_b_im);
    assign w_d_re = (IW+1)'(i_a_re) - (IW+1)'(i_b_re);
    assign w_d_im = (IW+1)'(i_a_im) - (IW+1)'(i_b_im);

    assign o_s_re = OW'(w_s_re >>> SHIFT);
    assign o_s_im = OW'(w_s_im >>> SHIFT);
    assign o_d_re = OW'(w_d_re >>> SHIFT);
    assign o_d_im = OW'(w_d_im >>> SHIFT);

endmodule

// File: rtl/fft4_stream.sv
// Two-stage pipelined 4-point radix-2 DIT FFT/IFFT with valid/ready flow control.
module fft4_stream
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SCALE = SCALE_SAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [4*WIDTH-1:0] in_re,
    input  logic [4*WIDTH-1:0] in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*WIDTH-1:0] out_re,
    output logic [4*WIDTH-1:0] out_im,
    output logic               ovf,
    input  logic               ovf_clr
);

    localparam int SH  = (SCALE == SCALE_SHIFT) ? 1 : 0;
    localparam int S1W = WIDTH + 1 - SH;
    localparam int EW  = WIDTH + 2;
    localparam int OW2 = S1W + 1 - SH;

    logic w_s1_adv;
    logic w_s2_adv;
    logic r_s1_v;
    logic r_s2_v;
    logic r_ovf;
    logic w_sat;

    logic [4*WIDTH-1:0] r_out_re;
    logic [4*WIDTH-1:0] r_out_im;

    logic signed [WIDTH-1:0] w_x_re [FFT4_N];
    logic signed [WIDTH-1:0] w_x_im [FFT4_N];

    logic signed [WIDTH:0] w_a0_re, w_a0_im, w_a1_re, w_a1_im;
    logic signed [WIDTH:0] w_b0_re, w_b0_im, w_d_re, w_d_im;

    logic signed [EW-1:0]  w_n_re [FFT4_N];
    logic signed [EW-1:0]  w_n_im [FFT4_N];
    logic signed [S1W-1:0] r_s1_re [FFT4_N];
    logic signed [S1W-1:0] r_s1_im [FFT4_N];
    logic signed [OW2-1:0] w_y_re [FFT4_N];
    logic signed [OW2-1:0] w_y_im [FFT4_N];
    logic signed [63:0]    w_z_re [FFT4_N];
    logic signed [63:0]    w_z_im [FFT4_N];

    assign w_s2_adv  = !r_s2_v || out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_v;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign ovf       = r_ovf;

    always_comb begin
        for (int n = 0; n < FFT4_N; n++) begin
            w_x_re[n] = in_re[n*WIDTH +: WIDTH];
            w_x_im[n] = in_im[n*WIDTH +: WIDTH];
        end
    end

    fft_bfly2 #(.IW(WIDTH), .SHIFT(0)) u_bf_02 (
        .i_a_re (w_x_re[0]), .i_a_im (w_x_im[0]),
        .i_b_re (w_x_re[2]), .i_b_im (w_x_im[2]),
        .o_s_re (w_a0_re),   .o_s_im (w_a0_im),
        .o_d_re (w_a1_re),   .o_d_im (w_a1_im)
    );

    fft_bfly2 #(.IW(WIDTH), .SHIFT(0)) u_bf_13 (
        .i_a_re (w_x_re[1]), .i_a_im (w_x_im[1]),
        .i_b_re (w_x_re[3]), .i_b_im (w_x_im[3]),
        .o_s_re (w_b0_re),   .o_s_im (w_b0_im),
        .o_d_re (w_d_re),    .o_d_im (w_d_im)
    );

    // Twiddle negates at EW bits before any scaling so the result is exact
    always_comb begin
        w_n_re[0] = EW'(w_a0_re);
        w_n_im[0] = EW'(w_a0_im);
        w_n_re[1] = EW'(w_a1_re);
        w_n_im[1] = EW'(w_a1_im);
        w_n_re[2] = EW'(w_b0_re);
        w_n_im[2] = EW'(w_b0_im);
        if (in_inv) begin
            w_n_re[3] = -EW'(w_d_im);
            w_n_im[3] = EW'(w_d_re);
        end else begin
            w_n_re[3] = EW'(w_d_im);
            w_n_im[3] = -EW'(w_d_re);
        end
    end

    fft_bfly2 #(.IW(S1W), .SHIFT(SH)) u_bf_x02 (
        .i_a_re (r_s1_re[0]), .i_a_im (r_s1_im[0]),
        .i_b_re (r_s1_re[2]), .i_b_im (r_s1_im[2]),
        .o_s_re (w_y_re[0]),  .o_s_im (w_y_im[0]),
        .o_d_re (w_y_re[2]),  .o_d_im (w_y_im[2])
    );

    fft_bfly2 #(.IW(S1W), .SHIFT(SH)) u_bf_x13 (
        .i_a_re (r_s1_re[1]), .i_a_im (r_s1_im[1]),
        .i_b_re (r_s1_re[3]), .i_b_im (r_s1_im[3]),
        .o_s_re (w_y_re[1]),  .o_s_im (w_y_im[1]),
        .o_d_re (w_y_re[3]),  .o_d_im (w_y_im[3])
    );

    always_comb begin
        w_sat = 1'b0;
        for (int n = 0; n < FFT4_N; n++) begin
            w_z_re[n] = sat(64'(w_y_re[n]), WIDTH);
            w_z_im[n] = sat(64'(w_y_im[n]), WIDTH);
            if (w_z_re[n] != 64'(w_y_re[n]) ||
                w_z_im[n] != 64'(w_y_im[n])) begin
                w_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_ovf    <= 1'b0;
            r_out_re <= '0;
            r_out_im <= '0;
            for (int n = 0; n < FFT4_N; n++) begin
                r_s1_re[n] <= '0;
                r_s1_im[n] <= '0;
            end
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    for (int n = 0; n < FFT4_N; n++) begin
                        r_s1_re[n] <= S1W'(w_n_re[n] >>> SH);
                        r_s1_im[n] <= S1W'(w_n_im[n] >>> SH);
                    end
                end
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    for (int n = 0; n < FFT4_N; n++) begin
                        r_out_re[n*WIDTH +: WIDTH] <= w_z_re[n][WIDTH-1:0];
                        r_out_im[n*WIDTH +: WIDTH] <= w_z_im[n][WIDTH-1:0];
                    end
                end
            end
            // A new saturation wins over a clear in the same cycle
            r_ovf <= (SCALE == SCALE_SAT) &&
                     ((w_s2_adv && r_s1_v && w_sat) || (r_ovf && !ovf_clr));
        end
    end

endmodule
